// File: rtl/scs8hd_dlyline_tap_ctrl_if.sv
// Request/tap bundle between delay-trim config logic (master) and the tap sequencer (slave).
interface scs8hd_dlyline_tap_ctrl_if #(
    parameter int TAP_W = 5
) ();
    logic             req;
    logic [TAP_W-1:0] target;
    logic [TAP_W-1:0] tap;
    logic             step_strobe;
    logic             busy;
    logic             ack;
    logic             err;

    modport master (
        output req, target,
        input  tap, step_strobe, busy, ack, err
    );

    modport slave (
        input  req, target,
        output tap, step_strobe, busy, ack, err
    );
endinterface

// File: rtl/scs8hd_dlyline_tap_ctrl.sv
// Walks the delay-line tap select to a requested target one tap per step, with a settle gap.
// Optional macro DLYCTRL_SATURATE_EN: clamp out-of-range targets instead of rejecting them.
module scs8hd_dlyline_tap_ctrl #(
    parameter int TAP_W    = 5,
    parameter int MAX_TAP  = 31,
    parameter int SETTLE   = 4,
    parameter int SETTLE_W = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    scs8hd_dlyline_tap_ctrl_if.slave      bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [TAP_W-1:0]    MAX_T     = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0]    TAP_ONE   = TAP_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);
    localparam logic [SETTLE_W-1:0] CNT_ONE   = SETTLE_W'(1);

    logic [1:0]          r_state;
    logic [TAP_W-1:0]    r_tgt;
    logic [TAP_W-1:0]    r_tap;
    logic [SETTLE_W-1:0] r_cnt;
    logic                r_strobe;
    logic                r_busy;
    logic                r_ack;
    logic                r_err;

    logic [TAP_W-1:0]    w_tgt_in;
    logic                w_bad;
    logic                w_up;

    always_comb begin
`ifdef DLYCTRL_SATURATE_EN
        w_tgt_in = (bus.target > MAX_T) ? MAX_T : bus.target;
        w_bad    = 1'b0;
`else
        w_tgt_in = bus.target;
        w_bad    = (bus.target > MAX_T);
`endif
    end

    assign w_up = (r_tgt > r_tap);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_tgt    <= '0;
            r_tap    <= '0;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        if (w_bad) begin
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_tgt_in == r_tap) begin
                            r_tgt   <= w_tgt_in;
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                        end else begin
                            r_tgt   <= w_tgt_in;
                            r_state <= S_STEP;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    // Target is always in range and differs from tap here, so no wrap is possible.
                    r_tap    <= w_up ? (r_tap + TAP_ONE) : (r_tap - TAP_ONE);
                    r_cnt    <= SETTLE_LD;
                    r_strobe <= 1'b1;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        if (r_tap == r_tgt) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_STEP;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tap         = r_tap;
    assign bus.step_strobe = r_strobe;
    assign bus.busy        = r_busy;
    assign bus.ack         = r_ack;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_scs8hd_dlyline_tap_ctrl.sv
// Randomized bench for the tap sequencer against a timeline model of each walk.
module tb_scs8hd_dlyline_tap_ctrl;

    localparam int TAP_W    = 5;
    localparam int MAX_TAP  = 20;
    localparam int SETTLE   = 4;
    localparam int SETTLE_W = 3;
    localparam int P        = SETTLE + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    scs8hd_dlyline_tap_ctrl_if #(.TAP_W(TAP_W)) dl ();

    scs8hd_dlyline_tap_ctrl #(
        .TAP_W   (TAP_W),
        .MAX_TAP (MAX_TAP),
        .SETTLE  (SETTLE),
        .SETTLE_W(SETTLE_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dl)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_tap   = 0;
    logic [8:0] obs[$];

    function automatic bit is_bad(input int traw);
`ifdef DLYCTRL_SATURATE_EN
        return 1'b0;
`else
        return traw > MAX_TAP;
`endif
    endfunction

    function automatic int eff_tgt(input int start, input int traw);
        if (traw > MAX_TAP) begin
`ifdef DLYCTRL_SATURATE_EN
            return MAX_TAP;
`else
            return start;
`endif
        end
        return traw;
    endfunction

    function automatic int walk_len(input int start, input int traw);
        int e;
        e = eff_tgt(start, traw);
        return ((e > start) ? (e - start) : (start - e)) * P;
    endfunction

    // Expected {tap, busy, ack, err, strobe} t cycles after the accepting edge.
    function automatic logic [8:0] expect_at(input int start, input int traw, input int t, input bit hold);
        int e, n, tt, k, tp;
        logic [4:0] tp5;
        logic busy, ack, err, stb;
        e  = eff_tgt(start, traw);
        n  = (e > start) ? (e - start) : (start - e);
        tt = n * P;
        if (t <= tt) begin
            k = (t == 0) ? 0 : ((t - 1) / P + 1);
            if (k > n) k = n;
            tp   = (e >= start) ? (start + k) : (start - k);
            busy = (t < tt);
            ack  = (t == tt);
            stb  = (t >= 1) && (t < tt) && (((t - 1) % P) == 0);
        end else begin
            tp   = e;
            busy = 1'b0;
            stb  = 1'b0;
            ack  = hold && (((t - tt) % 2) == 0);
        end
        err = ack && is_bad(traw);
        tp5 = tp[4:0];
        return {tp5, busy, ack, err, stb};
    endfunction

    // Issues one request and records outputs #1 after each of the following edges.
    task automatic run_walk(input int tgt, input int cycles, input bit hold,
                            input int inj_t, input int inj_tgt, input int rst_t);
        obs.delete();
        @(negedge clk);
        dl.req    = 1'b1;
        dl.target = tgt[4:0];
        for (int t = 0; t < cycles; t++) begin
            @(posedge clk);
            #1;
            obs.push_back({dl.tap, dl.busy, dl.ack, dl.err, dl.step_strobe});
            if (!hold) begin
                dl.req = (t == inj_t);
                if (t == inj_t) dl.target = inj_tgt[4:0];
            end
            reset = (rst_t >= 1) && (t == rst_t - 1);
        end
        dl.req = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic test_reset;
        logic [8:0] v;
        reset     = 1'b1;
        dl.req    = 1'b1;
        dl.target = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            v = {dl.tap, dl.busy, dl.ack, dl.err, dl.step_strobe};
            n_tests++;
            if (v !== 9'd0) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got %b required %b", i, v, 9'd0);
            end
        end
        reset  = 1'b0;
        dl.req = 1'b0;
        m_tap  = 0;
        @(posedge clk);
    endtask

    task automatic test_walk_up;
        logic [8:0] e;
        run_walk(3, walk_len(m_tap, 3) + 3, 1'b0, -1, 0, 0);
        for (int t = 0; t < obs.size(); t++) begin
            e = expect_at(m_tap, 3, t, 1'b0);
            n_tests++;
            if (obs[t] !== e) begin
                n_fail++;
                $display("FAIL walk_up t=%0d got %b required %b", t, obs[t], e);
            end
        end
        m_tap = eff_tgt(m_tap, 3);
    endtask

    task automatic test_zero_step;
        logic [8:0] e;
        run_walk(m_tap, 4, 1'b0, -1, 0, 0);
        for (int t = 0; t < obs.size(); t++) begin
            e = expect_at(m_tap, m_tap, t, 1'b0);
            n_tests++;
            if (obs[t] !== e) begin
                n_fail++;
                $display("FAIL zero_step t=%0d got %b required %b", t, obs[t], e);
            end
        end
    endtask

    task automatic test_walk_down;
        logic [8:0] e;
        run_walk(0, walk_len(m_tap, 0) + 3, 1'b0, -1, 0, 0);
        for (int t = 0; t < obs.size(); t++) begin
            e = expect_at(m_tap, 0, t, 1'b0);
            n_tests++;
            if (obs[t] !== e) begin
                n_fail++;
                $display("FAIL walk_down t=%0d got %b required %b", t, obs[t], e);
            end
        end
        m_tap = 0;
    endtask

    task automatic test_ignore_req;
        logic [8:0] e;
        int len, inj;
        len = walk_len(m_tap, 10);
        inj = $urandom_range(0, len);
        run_walk(10, len + 3, 1'b0, inj, 2, 0);
        for (int t = 0; t < obs.size(); t++) begin
            e = expect_at(m_tap, 10, t, 1'b0);
            n_tests++;
            if (obs[t] !== e) begin
                n_fail++;
                $display("FAIL ignore_req inj=%0d t=%0d got %b required %b", inj, t, obs[t], e);
            end
        end
        m_tap = 10;
    endtask

    task automatic test_out_of_range;
        int seq[6] = '{18, 25, 21, 20, 21, 0};
        logic [8:0] e;
        foreach (seq[i]) begin
            run_walk(seq[i], walk_len(m_tap, seq[i]) + 3, 1'b0, -1, 0, 0);
            for (int t = 0; t < obs.size(); t++) begin
                e = expect_at(m_tap, seq[i], t, 1'b0);
                n_tests++;
                if (obs[t] !== e) begin
                    n_fail++;
                    $display("FAIL range from=%0d tgt=%0d t=%0d got %b required %b",
                             m_tap, seq[i], t, obs[t], e);
                end
            end
            m_tap = eff_tgt(m_tap, seq[i]);
        end
    endtask

    task automatic test_reset_midwalk;
        logic [8:0] e;
        run_walk(0, walk_len(m_tap, 0) + 3, 1'b0, -1, 0, 0);
        m_tap = 0;
        run_walk(5, 12, 1'b0, -1, 0, 7);
        for (int t = 0; t < obs.size(); t++) begin
            e = (t >= 7) ? 9'd0 : expect_at(0, 5, t, 1'b0);
            n_tests++;
            if (obs[t] !== e) begin
                n_fail++;
                $display("FAIL reset_midwalk t=%0d got %b required %b", t, obs[t], e);
            end
        end
        m_tap = 0;
        run_walk(4, walk_len(0, 4) + 3, 1'b0, -1, 0, 0);
        for (int t = 0; t < obs.size(); t++) begin
            e = expect_at(0, 4, t, 1'b0);
            n_tests++;
            if (obs[t] !== e) begin
                n_fail++;
                $display("FAIL after_reset t=%0d got %b required %b", t, obs[t], e);
            end
        end
        m_tap = 4;
    endtask

    task automatic test_back_to_back;
        logic [8:0] e;
        run_walk(7, walk_len(m_tap, 7) + 6, 1'b1, -1, 0, 0);
        for (int t = 0; t < obs.size(); t++) begin
            e = expect_at(m_tap, 7, t, 1'b1);
            n_tests++;
            if (obs[t] !== e) begin
                n_fail++;
                $display("FAIL back_to_back t=%0d got %b required %b", t, obs[t], e);
            end
        end
        m_tap = 7;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random;
        logic [8:0] e;
        int traw, len, inj, itgt;
        for (int i = 0; i < 12; i++) begin
            traw = $urandom_range(0, 31);
            len  = walk_len(m_tap, traw);
            inj  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len)) : -1;
            itgt = $urandom_range(0, 31);
            run_walk(traw, len + 3, 1'b0, inj, itgt, 0);
            for (int t = 0; t < obs.size(); t++) begin
                e = expect_at(m_tap, traw, t, 1'b0);
                n_tests++;
                if (obs[t] !== e) begin
                    n_fail++;
                    $display("FAIL random from=%0d tgt=%0d t=%0d got %b required %b",
                             m_tap, traw, t, obs[t], e);
                end
            end
            m_tap = eff_tgt(m_tap, traw);
        end
    endtask

    initial begin
        dl.req    = 1'b0;
        dl.target = '0;
        test_reset();
        test_walk_up();
        test_zero_step();
        test_walk_down();
        test_ignore_req();
        test_out_of_range();
        test_reset_midwalk();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
